// File: rtl/test_stream_checker_if.sv
// AXI4-Stream handshake bundle between a stream source and the stream checker.
interface test_stream_checker_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/test_stream_checker.sv
// AXI4-Stream packet sink that checks lane patterns and gathers capture statistics.
module test_stream_checker #(
    parameter int LANE_WIDTH  = 16,
    parameter int NUM_LANES   = 2,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [COUNT_WIDTH-1:0] beat_limit,
    output logic                   idle,
    output logic                   done,
    output logic                   end_cause,
    test_stream_checker_if.slave   axis,
    output logic [COUNT_WIDTH-1:0] beat_count,
    output logic [COUNT_WIDTH-1:0] miss_count,
    output logic [COUNT_WIDTH-1:0] error_count,
    output logic [COUNT_WIDTH-1:0] first_error_beat,
    output logic                   first_error_valid,
    output logic [NUM_LANES-1:0]   error_lane_mask
);
    localparam int DW = LANE_WIDTH * NUM_LANES;
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                 state_r;
    logic                   tready_r;
    logic                   idle_r;
    logic                   done_r;
    logic                   end_cause_r;
    logic [1:0]             mode_r;
    logic [COUNT_WIDTH-1:0] limit_r;
    logic [DW-1:0]          ref_r;
    logic [COUNT_WIDTH-1:0] beat_count_r;
    logic [COUNT_WIDTH-1:0] miss_count_r;
    logic [COUNT_WIDTH-1:0] error_count_r;
    logic [COUNT_WIDTH-1:0] first_error_beat_r;
    logic                   first_error_valid_r;
    logic [NUM_LANES-1:0]   error_lane_mask_r;

    logic                   accept_s;
    logic [COUNT_WIDTH-1:0] beat_next_s;
    logic                   limit_hit_s;
    logic                   end_s;
    logic [NUM_LANES-1:0]   mismatch_s;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        logic [COUNT_WIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // A start in the same cycle discards the beat, so it never counts as accepted.
    assign accept_s    = tready_r & axis.tvalid & ~start;
    assign beat_next_s = sat_inc(beat_count_r);
    assign limit_hit_s = (limit_r != CNT_ZERO) && (beat_next_s == limit_r);
    assign end_s       = accept_s & (axis.tlast | limit_hit_s);

    // Per-lane comparison against the pattern reference for the current mode.
    always_comb begin
        logic [LANE_WIDTH-1:0] lane_v;
        logic [LANE_WIDTH-1:0] exp_v;
        mismatch_s = {NUM_LANES{1'b0}};
        lane_v     = {LANE_WIDTH{1'b0}};
        exp_v      = {LANE_WIDTH{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_v = axis.tdata[i*LANE_WIDTH +: LANE_WIDTH];
            case (mode_r)
                2'd0: begin
                    if (state_r == ST_ARMED) begin
                        exp_v = axis.tdata[LANE_WIDTH-1:0] + LANE_WIDTH'(i);
                    end else begin
                        exp_v = ref_r[LANE_WIDTH-1:0] + LANE_WIDTH'(NUM_LANES + i);
                    end
                    mismatch_s[i] = (lane_v != exp_v);
                end
                2'd1: begin
                    if (state_r == ST_RUN) begin
                        mismatch_s[i] = (lane_v != ref_r[i*LANE_WIDTH +: LANE_WIDTH]);
                    end else begin
                        mismatch_s[i] = 1'b0;
                    end
                end
                default: begin
                    mismatch_s[i] = 1'b0;
                end
            endcase
        end
    end

    // Capture FSM with all status registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r             <= ST_IDLE;
            tready_r            <= 1'b0;
            idle_r              <= 1'b1;
            done_r              <= 1'b0;
            end_cause_r         <= 1'b0;
            mode_r              <= 2'd0;
            limit_r             <= CNT_ZERO;
            ref_r               <= {DW{1'b0}};
            beat_count_r        <= CNT_ZERO;
            miss_count_r        <= CNT_ZERO;
            error_count_r       <= CNT_ZERO;
            first_error_beat_r  <= CNT_ZERO;
            first_error_valid_r <= 1'b0;
            error_lane_mask_r   <= {NUM_LANES{1'b0}};
        end else if (start) begin
            state_r             <= ST_ARMED;
            tready_r            <= 1'b1;
            idle_r              <= 1'b0;
            done_r              <= 1'b0;
            end_cause_r         <= 1'b0;
            mode_r              <= mode;
            limit_r             <= beat_limit;
            beat_count_r        <= CNT_ZERO;
            miss_count_r        <= CNT_ZERO;
            error_count_r       <= CNT_ZERO;
            first_error_beat_r  <= CNT_ZERO;
            first_error_valid_r <= 1'b0;
            error_lane_mask_r   <= {NUM_LANES{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tready_r <= 1'b0;
                    idle_r   <= 1'b1;
                end
                ST_ARMED, ST_RUN: begin
                    if (accept_s) begin
                        beat_count_r <= beat_next_s;
                        if (|mismatch_s) begin
                            error_count_r     <= sat_inc(error_count_r);
                            error_lane_mask_r <= error_lane_mask_r | mismatch_s;
                            if (!first_error_valid_r) begin
                                first_error_beat_r  <= beat_count_r;
                                first_error_valid_r <= 1'b1;
                            end
                        end
                        // Increment mode tracks every lane0; constant mode keeps the first beat.
                        if ((mode_r == 2'd0) || (state_r == ST_ARMED)) begin
                            ref_r <= axis.tdata;
                        end
                        if (end_s) begin
                            state_r     <= ST_IDLE;
                            tready_r    <= 1'b0;
                            idle_r      <= 1'b1;
                            done_r      <= 1'b1;
                            end_cause_r <= ~axis.tlast;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else if (!axis.tvalid) begin
                        miss_count_r <= sat_inc(miss_count_r);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    tready_r <= 1'b0;
                    idle_r   <= 1'b1;
                end
            endcase
        end
    end

    assign axis.tready       = tready_r;
    assign idle              = idle_r;
    assign done              = done_r;
    assign end_cause         = end_cause_r;
    assign beat_count        = beat_count_r;
    assign miss_count        = miss_count_r;
    assign error_count       = error_count_r;
    assign first_error_beat  = first_error_beat_r;
    assign first_error_valid = first_error_valid_r;
    assign error_lane_mask   = error_lane_mask_r;
endmodule

// File: tb/tb_test_stream_checker.sv
// Directed bench for test_stream_checker: packet scenario table plus corner-case sequences.
module tb_test_stream_checker;
    logic        clk;
    logic        resetn;
    logic        start_s;
    logic [1:0]  mode_s;
    logic [31:0] limit_s;
    logic        idle_s, done_s, cause_s, fev_s;
    logic [31:0] beat_s, miss_s, err_s, feb_s;
    logic [1:0]  mask_s;

    logic        start4_s;
    logic [3:0]  limit4_s;
    logic        idle4_s, done4_s, cause4_s, fev4_s;
    logic [3:0]  beat4_s, miss4_s, err4_s, feb4_s;
    logic [1:0]  mask4_s;

    int total = 0;
    int bad   = 0;

    test_stream_checker_if #(.DATA_WIDTH(32)) axis_bus ();
    test_stream_checker_if #(.DATA_WIDTH(32)) axis4_bus ();

    test_stream_checker #(.LANE_WIDTH(16), .NUM_LANES(2), .COUNT_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start(start_s), .mode(mode_s), .beat_limit(limit_s),
        .idle(idle_s), .done(done_s), .end_cause(cause_s), .axis(axis_bus.slave),
        .beat_count(beat_s), .miss_count(miss_s), .error_count(err_s),
        .first_error_beat(feb_s), .first_error_valid(fev_s), .error_lane_mask(mask_s)
    );

    test_stream_checker #(.LANE_WIDTH(16), .NUM_LANES(2), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .resetn(resetn), .start(start4_s), .mode(2'd0), .beat_limit(limit4_s),
        .idle(idle4_s), .done(done4_s), .end_cause(cause4_s), .axis(axis4_bus.slave),
        .beat_count(beat4_s), .miss_count(miss4_s), .error_count(err4_s),
        .first_error_beat(feb4_s), .first_error_valid(fev4_s), .error_lane_mask(mask4_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] limit;
        int          nbeats;
        int          tlast_at;
        int          gap_after;
        int          gap_len;
        int          skip_at;
        int          corrupt_at;
        bit          cdata;
        logic [31:0] e_beat;
        logic [31:0] e_miss;
        logic [31:0] e_err;
        logic [31:0] e_feb;
        logic        e_fev;
        logic [1:0]  e_mask;
        logic        e_cause;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input vec_t v, input int k);
        logic [15:0] l0;
        logic [15:0] l1;
        if (v.cdata) begin
            l0 = 16'h1234;
            l1 = 16'hA5A5;
        end else begin
            l0 = 16'(2 * k + (((v.skip_at >= 0) && (k >= v.skip_at)) ? 2 : 0));
            l1 = l0 + 16'd1;
        end
        if (k == v.corrupt_at) l1 = 16'h0000;
        return {l1, l0};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int dones = 0;
        @(negedge clk);
        start_s = 1'b1; mode_s = v.mode; limit_s = v.limit;
        axis_bus.tvalid = 1'b0; axis_bus.tlast = 1'b0;
        @(negedge clk);
        start_s = 1'b0;
        for (int k = 0; k < v.nbeats; k++) begin
            if (!axis_bus.tready) break;
            axis_bus.tvalid = 1'b1;
            axis_bus.tdata  = beat_data(v, k);
            axis_bus.tlast  = (k == v.tlast_at);
            @(negedge clk);
            if (done_s) dones++;
            if (k == v.gap_after) begin
                axis_bus.tvalid = 1'b0; axis_bus.tlast = 1'b0;
                for (int g = 0; g < v.gap_len; g++) begin
                    @(negedge clk);
                    if (done_s) dones++;
                end
            end
        end
        axis_bus.tvalid = 1'b0; axis_bus.tlast = 1'b0;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            if (done_s) dones++;
        end
        chk($sformatf("v%0d beat_count", idx), beat_s, v.e_beat);
        chk($sformatf("v%0d miss_count", idx), miss_s, v.e_miss);
        chk($sformatf("v%0d error_count", idx), err_s, v.e_err);
        chk($sformatf("v%0d first_error_beat", idx), feb_s, v.e_feb);
        chk($sformatf("v%0d first_error_valid", idx), 32'(fev_s), 32'(v.e_fev));
        chk($sformatf("v%0d error_lane_mask", idx), 32'(mask_s), 32'(v.e_mask));
        chk($sformatf("v%0d end_cause", idx), 32'(cause_s), 32'(v.e_cause));
        chk($sformatf("v%0d done_pulses", idx), 32'(dones), 32'd1);
        chk($sformatf("v%0d idle", idx), 32'(idle_s), 32'd1);
        chk($sformatf("v%0d tready", idx), 32'(axis_bus.tready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //        mode  limit  n  tl  gapA gapL skip cor  c  beat miss err feb fev mask cause
        vecs[0] = '{2'd0, 32'd0, 8,  7, -1, 0, -1, -1, 1'b0, 32'd8, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{2'd0, 32'd0, 8,  7,  1, 3, -1, -1, 1'b0, 32'd8, 32'd3, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0};
        vecs[2] = '{2'd0, 32'd0, 8,  7, -1, 0,  3, -1, 1'b0, 32'd8, 32'd0, 32'd1, 32'd3, 1'b1, 2'b11, 1'b0};
        vecs[3] = '{2'd0, 32'd5, 10, -1, -1, 0, -1, -1, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b1};
        vecs[4] = '{2'd0, 32'd8, 8,  7, -1, 0, -1, -1, 1'b0, 32'd8, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0};
        vecs[5] = '{2'd1, 32'd0, 6,  5, -1, 0, -1,  3, 1'b1, 32'd6, 32'd0, 32'd1, 32'd3, 1'b1, 2'b10, 1'b0};
        vecs[6] = '{2'd0, 32'd0, 4,  3, -1, 0, -1,  0, 1'b0, 32'd4, 32'd0, 32'd1, 32'd0, 1'b1, 2'b10, 1'b0};
        vecs[7] = '{2'd2, 32'd0, 4,  3, -1, 0, -1,  1, 1'b0, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0};
        vecs[8] = '{2'd3, 32'd0, 4,  3, -1, 0,  1,  2, 1'b0, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0};
        vecs[9] = '{2'd0, 32'd3, 6, -1,  0, 2, -1, -1, 1'b0, 32'd3, 32'd2, 32'd0, 32'd0, 1'b0, 2'b00, 1'b1};

        resetn = 1'b0; start_s = 1'b0; mode_s = 2'd0; limit_s = 32'd0;
        axis_bus.tvalid = 1'b0; axis_bus.tlast = 1'b0; axis_bus.tdata = 32'd0;
        start4_s = 1'b0; limit4_s = 4'd0;
        axis4_bus.tvalid = 1'b0; axis4_bus.tlast = 1'b0; axis4_bus.tdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset idle", 32'(idle_s), 32'd1);
        chk("reset tready", 32'(axis_bus.tready), 32'd0);
        chk("reset done", 32'(done_s), 32'd0);
        chk("reset beat_count", beat_s, 32'd0);
        chk("reset miss_count", miss_s, 32'd0);
        chk("reset error_count", err_s, 32'd0);
        chk("reset end_cause", 32'(cause_s), 32'd0);
        chk("reset first_error_valid", 32'(fev_s), 32'd0);
        chk("reset error_lane_mask", 32'(mask_s), 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Beat coincident with start is not taken; then a mid-capture restart.
        @(negedge clk);
        start_s = 1'b1; mode_s = 2'd0; limit_s = 32'd0;
        axis_bus.tvalid = 1'b1; axis_bus.tdata = {16'd1, 16'd0}; axis_bus.tlast = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        chk("startbeat beat_count", beat_s, 32'd0);
        chk("startbeat idle", 32'(idle_s), 32'd0);
        chk("startbeat tready", 32'(axis_bus.tready), 32'd1);
        chk("startbeat done", 32'(done_s), 32'd0);
        axis_bus.tlast = 1'b0;
        axis_bus.tdata = {16'd3, 16'd2};
        @(negedge clk);
        axis_bus.tdata = {16'd5, 16'd4};
        @(negedge clk);
        axis_bus.tdata = {16'd0, 16'd0};
        @(negedge clk);
        chk("pre-restart beat_count", beat_s, 32'd3);
        chk("pre-restart error_count", err_s, 32'd1);
        chk("pre-restart first_error_beat", feb_s, 32'd2);
        chk("pre-restart error_lane_mask", 32'(mask_s), 32'd3);
        start_s = 1'b1;
        axis_bus.tdata = {16'd7, 16'd6};
        @(negedge clk);
        start_s = 1'b0;
        chk("restart beat_count", beat_s, 32'd0);
        chk("restart miss_count", miss_s, 32'd0);
        chk("restart error_count", err_s, 32'd0);
        chk("restart first_error_valid", 32'(fev_s), 32'd0);
        chk("restart error_lane_mask", 32'(mask_s), 32'd0);
        chk("restart idle", 32'(idle_s), 32'd0);
        chk("restart tready", 32'(axis_bus.tready), 32'd1);
        axis_bus.tdata = {16'd101, 16'd100}; axis_bus.tlast = 1'b1;
        @(negedge clk);
        axis_bus.tvalid = 1'b0; axis_bus.tlast = 1'b0;
        chk("rearmed beat_count", beat_s, 32'd1);
        chk("rearmed error_count", err_s, 32'd0);
        chk("rearmed done", 32'(done_s), 32'd1);
        chk("rearmed idle", 32'(idle_s), 32'd1);

        // Reset in the middle of a capture, with start asserted at the same edge.
        @(negedge clk);
        start_s = 1'b1; mode_s = 2'd0; limit_s = 32'd0;
        @(negedge clk);
        start_s = 1'b0;
        axis_bus.tvalid = 1'b1; axis_bus.tdata = {16'd1, 16'd0};
        @(negedge clk);
        axis_bus.tdata = {16'd0, 16'd9};
        @(negedge clk);
        chk("pre-reset error_count", err_s, 32'd1);
        resetn = 1'b0; start_s = 1'b1;
        @(negedge clk);
        resetn = 1'b1; start_s = 1'b0; axis_bus.tvalid = 1'b0;
        chk("midreset idle", 32'(idle_s), 32'd1);
        chk("midreset tready", 32'(axis_bus.tready), 32'd0);
        chk("midreset done", 32'(done_s), 32'd0);
        chk("midreset beat_count", beat_s, 32'd0);
        chk("midreset miss_count", miss_s, 32'd0);
        chk("midreset error_count", err_s, 32'd0);
        chk("midreset first_error_beat", feb_s, 32'd0);
        chk("midreset first_error_valid", 32'(fev_s), 32'd0);
        chk("midreset error_lane_mask", 32'(mask_s), 32'd0);
        chk("midreset end_cause", 32'(cause_s), 32'd0);

        // Narrow counters saturate instead of wrapping.
        @(negedge clk);
        start4_s = 1'b1;
        @(negedge clk);
        start4_s = 1'b0;
        repeat (20) @(negedge clk);
        chk("sat miss_count", 32'(miss4_s), 32'd15);
        axis4_bus.tvalid = 1'b1; axis4_bus.tdata = {16'd1, 16'd0}; axis4_bus.tlast = 1'b1;
        @(negedge clk);
        axis4_bus.tvalid = 1'b0; axis4_bus.tlast = 1'b0;
        chk("sat beat_count", 32'(beat4_s), 32'd1);
        chk("sat miss_held", 32'(miss4_s), 32'd15);
        chk("sat done", 32'(done4_s), 32'd1);
        chk("sat error_count", 32'(err4_s), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
